// File: rtl/pc_controller_pkg.sv
// Shared CPU definitions for the program-counter controller: FSM encoding and reset vector.
package pc_controller_pkg;

  localparam logic [15:0] PC_RESET_DEFAULT = 16'hFFFC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BR_FIX = 2'd1,
    PUSH_H = 2'd2,
    PUSH_L = 2'd3
  } pc_state_t;

endpackage

// File: rtl/pc_controller_incrementer.sv
// 8-bit adder with carry-in and carry-out, used for both PC byte paths.
module pc_incrementer (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [8:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {8'h00, i_cin};
  assign o_sum  = w_full[7:0];
  assign o_cout = w_full[8];

endmodule

// File: rtl/pc_controller.sv
// Program-counter controller: INC/JMP/relative branch with page fix-up, and two-cycle PC push.
module pc_controller
  import pc_controller_pkg::*;
#(
  parameter logic [15:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        INC_REQ,
  input  logic        JMP_REQ,
  input  logic [7:0]  ADL_IN,
  input  logic [7:0]  ADH_IN,
  input  logic        BR_REQ,
  input  logic [7:0]  BR_OFFSET,
  input  logic        PUSH_REQ,
  input  logic        ADDR_EN,
  output logic [7:0]  PCL_DATA,
  output logic [7:0]  PCH_DATA,
  output logic        PCL_LOAD,
  output logic        PCH_LOAD,
  output logic        PCL_DB_EN,
  output logic        PCH_DB_EN,
  output logic        PCL_ADL_EN,
  output logic        PCH_ADH_EN,
  output logic [15:0] PC_OUT,
  output logic        BUSY
);

  pc_state_t   r_state;
  pc_state_t   w_state_next;
  logic [15:0] r_pc;
  logic        r_br_up;

  logic        w_idle;
  logic        w_do_jmp;
  logic        w_do_br;
  logic        w_do_push;
  logic        w_do_inc;
  logic        w_br_cross;
  logic [7:0]  w_pcl_b;
  logic        w_pcl_cin;
  logic [7:0]  w_pcl_sum;
  logic        w_pcl_cout;
  logic [7:0]  w_pch_b;
  logic        w_pch_cin;
  logic [7:0]  w_pch_sum;
  logic        w_pch_cout;
  logic [15:0] w_next_pc;
  logic [15:0] w_pc_d;

  // Request decode: priority JMP > BR > PUSH > INC, only honoured in IDLE.
  assign w_idle    = (r_state == IDLE);
  assign w_do_jmp  = w_idle & JMP_REQ;
  assign w_do_br   = w_idle & ~JMP_REQ & BR_REQ;
  assign w_do_push = w_idle & ~JMP_REQ & ~BR_REQ & PUSH_REQ;
  assign w_do_inc  = w_idle & ~JMP_REQ & ~BR_REQ & ~PUSH_REQ & INC_REQ;

  // Operand muxes kept as separate assigns so the PCL carry feeds PCH without a comb-block loop.
  assign w_pcl_b    = w_do_br ? BR_OFFSET : '0;
  assign w_pcl_cin  = w_do_inc;
  assign w_pch_b    = ((r_state == BR_FIX) && !r_br_up) ? '1 : '0;
  assign w_pch_cin  = (r_state == BR_FIX) ? r_br_up : (w_do_inc & w_pcl_cout);
  assign w_br_cross = BR_OFFSET[7] ? ~w_pcl_cout : w_pcl_cout;

  pc_incrementer u_pcl_inc (
    .i_a    (r_pc[7:0]),
    .i_b    (w_pcl_b),
    .i_cin  (w_pcl_cin),
    .o_sum  (w_pcl_sum),
    .o_cout (w_pcl_cout)
  );

  pc_incrementer u_pch_inc (
    .i_a    (r_pc[15:8]),
    .i_b    (w_pch_b),
    .i_cin  (w_pch_cin),
    .o_sum  (w_pch_sum),
    .o_cout (w_pch_cout)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_pc    <= RESET_PC;
      r_br_up <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (w_do_br) begin
        r_br_up <= ~BR_OFFSET[7];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_do_br && w_br_cross) begin
          w_state_next = BR_FIX;
        end else if (w_do_push) begin
          w_state_next = PUSH_H;
        end
      end
      BR_FIX:  w_state_next = IDLE;
      PUSH_H:  w_state_next = PUSH_L;
      PUSH_L:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_next_pc = r_pc;
    if (w_do_jmp) begin
      w_next_pc = {ADH_IN, ADL_IN};
    end else if (w_do_br) begin
      w_next_pc = {r_pc[15:8], w_pcl_sum};
    end else if (w_do_inc) begin
      w_next_pc = {w_pch_sum, w_pcl_sum};
    end else if (r_state == BR_FIX) begin
      w_next_pc = {w_pch_sum, r_pc[7:0]};
    end

    w_pc_d     = RESET_N ? w_next_pc : RESET_PC;
    PCL_DATA   = w_pc_d[7:0];
    PCH_DATA   = w_pc_d[15:8];
    PCL_LOAD   = RESET_N & (w_next_pc[7:0] != r_pc[7:0]);
    PCH_LOAD   = RESET_N & (w_next_pc[15:8] != r_pc[15:8]);
    PCH_DB_EN  = RESET_N & (r_state == PUSH_H);
    PCL_DB_EN  = RESET_N & (r_state == PUSH_L);
    PCL_ADL_EN = RESET_N & ADDR_EN & (r_state != PUSH_H) & (r_state != PUSH_L);
    PCH_ADH_EN = PCL_ADL_EN;
    BUSY       = RESET_N & (r_state != IDLE);
    PC_OUT     = r_pc;
  end

endmodule

// File: tb/tb_pc_controller.sv
// Self-checking bench for pc_controller: scoreboard of post-edge state plus inline pre-edge checks.
module tb_pc_controller;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        busy;
    logic        pch_db;
    logic        pcl_db;
    logic        adr;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        INC_REQ, JMP_REQ, BR_REQ, PUSH_REQ, ADDR_EN;
  logic [7:0]  ADL_IN, ADH_IN, BR_OFFSET;
  logic [7:0]  PCL_DATA, PCH_DATA;
  logic        PCL_LOAD, PCH_LOAD, PCL_DB_EN, PCH_DB_EN, PCL_ADL_EN, PCH_ADH_EN, BUSY;
  logic [15:0] PC_OUT;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  pc_controller #(.RESET_PC(16'hFFFC)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .INC_REQ    (INC_REQ),
    .JMP_REQ    (JMP_REQ),
    .ADL_IN     (ADL_IN),
    .ADH_IN     (ADH_IN),
    .BR_REQ     (BR_REQ),
    .BR_OFFSET  (BR_OFFSET),
    .PUSH_REQ   (PUSH_REQ),
    .ADDR_EN    (ADDR_EN),
    .PCL_DATA   (PCL_DATA),
    .PCH_DATA   (PCH_DATA),
    .PCL_LOAD   (PCL_LOAD),
    .PCH_LOAD   (PCH_LOAD),
    .PCL_DB_EN  (PCL_DB_EN),
    .PCH_DB_EN  (PCH_DB_EN),
    .PCL_ADL_EN (PCL_ADL_EN),
    .PCH_ADH_EN (PCH_ADH_EN),
    .PC_OUT     (PC_OUT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Scoreboard monitor: compares the state after every edge against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (PC_OUT !== e.pc || BUSY !== e.busy || PCH_DB_EN !== e.pch_db || PCL_DB_EN !== e.pcl_db ||
            PCL_ADL_EN !== e.adr || PCH_ADH_EN !== e.adr) begin
          n_errors++;
          $display("FAIL %s: got pc=%h busy=%b pch_db=%b pcl_db=%b adl=%b adh=%b, expected pc=%h busy=%b pch_db=%b pcl_db=%b adr=%b",
                   e.tag, PC_OUT, BUSY, PCH_DB_EN, PCL_DB_EN, PCL_ADL_EN, PCH_ADH_EN,
                   e.pc, e.busy, e.pch_db, e.pcl_db, e.adr);
        end
        n_checks++;
        if (PCH_DB_EN === 1'b1 && PCL_DB_EN === 1'b1) begin
          n_errors++;
          $display("FAIL %s_db_exclusive: got pch_db=1 pcl_db=1, expected at most one", e.tag);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic inc, input logic jmp, input logic br, input logic push,
                        input logic [15:0] tgt, input logic [7:0] off);
    INC_REQ = inc; JMP_REQ = jmp; BR_REQ = br; PUSH_REQ = push;
    ADH_IN = tgt[15:8]; ADL_IN = tgt[7:0]; BR_OFFSET = off;
  endtask

  task automatic expect_after(input string tag, input logic [15:0] pc, input logic busy,
                              input logic pch_db, input logic pcl_db, input logic adr);
    exp_t e;
    e.tag = tag; e.pc = pc; e.busy = busy; e.pch_db = pch_db; e.pcl_db = pcl_db; e.adr = adr;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; ADDR_EN = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    n_checks++;
    if (PCL_LOAD !== 1'b0 || PCH_LOAD !== 1'b0 || {PCH_DATA, PCL_DATA} !== 16'hFFFC) begin
      n_errors++;
      $display("FAIL reset_comb: got loads=%b%b data=%h, expected loads=00 data=fffc",
               PCH_LOAD, PCL_LOAD, {PCH_DATA, PCL_DATA});
    end
    expect_after("reset1", 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_after("reset2", 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    RESET_N = 1'b1; ADDR_EN = 1'b0;
  endtask

  task automatic test_inc();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    n_checks++;
    if (PCL_LOAD !== 1'b1 || PCH_LOAD !== 1'b0 || {PCH_DATA, PCL_DATA} !== 16'hFFFD) begin
      n_errors++;
      $display("FAIL inc1_comb: got pcl_load=%b pch_load=%b data=%h, expected 1 0 fffd",
               PCL_LOAD, PCH_LOAD, {PCH_DATA, PCL_DATA});
    end
    expect_after("inc1", 16'hFFFD, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    n_checks++;
    if (PCL_LOAD !== 1'b1 || PCH_LOAD !== 1'b0 || {PCH_DATA, PCL_DATA} !== 16'hFFFE) begin
      n_errors++;
      $display("FAIL inc2_comb: got pcl_load=%b pch_load=%b data=%h, expected 1 0 fffe",
               PCL_LOAD, PCH_LOAD, {PCH_DATA, PCL_DATA});
    end
    expect_after("inc2", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00);
    expect_after("jmp_ffff", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    n_checks++;
    if (PCL_LOAD !== 1'b1 || PCH_LOAD !== 1'b1 || {PCH_DATA, PCL_DATA} !== 16'h0000) begin
      n_errors++;
      $display("FAIL inc_wrap_comb: got pcl_load=%b pch_load=%b data=%h, expected 1 1 0000",
               PCL_LOAD, PCH_LOAD, {PCH_DATA, PCL_DATA});
    end
    expect_after("inc_wrap", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_branch_fwd();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 16'h12F0, 8'h00);
    expect_after("jmp_12f0", 16'h12F0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h20);
    expect_after("brf_c1", 16'h1210, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 8'h20);
    #1;
    n_checks++;
    if (PCH_LOAD !== 1'b1 || PCL_LOAD !== 1'b0 || {PCH_DATA, PCL_DATA} !== 16'h1310) begin
      n_errors++;
      $display("FAIL brf_fix_comb: got pch_load=%b pcl_load=%b data=%h, expected 1 0 1310",
               PCH_LOAD, PCL_LOAD, {PCH_DATA, PCL_DATA});
    end
    expect_after("brf_c2", 16'h1310, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    expect_after("brf_idle", 16'h1310, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_branch_back();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 16'h1205, 8'h00);
    expect_after("jmp_1205", 16'h1205, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'hF0);
    expect_after("brb_c1", 16'h12F5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    expect_after("brb_c2", 16'h11F5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 16'h1205, 8'h00);
    expect_after("jmp_1205b", 16'h1205, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h05);
    #1;
    n_checks++;
    if (PCH_LOAD !== 1'b0 || PCL_LOAD !== 1'b1) begin
      n_errors++;
      $display("FAIL br_same_page_load: got pch_load=%b pcl_load=%b, expected 0 1", PCH_LOAD, PCL_LOAD);
    end
    expect_after("br_same_page", 16'h120A, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_push();
    ADDR_EN = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD, 8'h00);
    expect_after("jmp_abcd", 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
    expect_after("push_h", 16'hABCD, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    expect_after("push_l", 16'hABCD, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    expect_after("push_done", 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    ADDR_EN = 1'b0;
  endtask

  task automatic test_priority();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 16'hC000, 8'h7F);
    expect_after("prio_jmp", 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h10);
    expect_after("prio_br", 16'hC010, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
    expect_after("prio_push", 16'hC010, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    expect_after("prio_push_l", 16'hC010, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    expect_after("prio_idle", 16'hC010, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_abort();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD, 8'h00);
    expect_after("ra_jmp", 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
    expect_after("ra_push_h", 16'hABCD, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    RESET_N = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    expect_after("ra_push_reset", 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    RESET_N = 1'b1;
    expect_after("ra_push_after", 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 16'h12F0, 8'h00);
    expect_after("ra_jmp2", 16'h12F0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h20);
    expect_after("ra_br_c1", 16'h1210, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    RESET_N = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    expect_after("ra_br_reset", 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    RESET_N = 1'b1;
    expect_after("ra_br_after", 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // Random request mix against a behavioural model using full 16-bit signed branch targets.
  task automatic test_back_to_back();
    logic [15:0] m_pc, m_tgt, nt, tgt;
    int unsigned m_phase;
    logic inc, jmp, br, push, adr;
    logic [7:0] off;
    m_pc = 16'hFFFC;
    m_tgt = 16'h0000;
    m_phase = 0;
    for (int i = 0; i < 80; i++) begin
      inc  = 1'($urandom_range(0, 1));
      jmp  = ($urandom_range(0, 3) == 0);
      br   = ($urandom_range(0, 2) == 0);
      push = ($urandom_range(0, 4) == 0);
      adr  = 1'($urandom_range(0, 1));
      tgt  = 16'($urandom);
      off  = 8'($urandom);
      case (m_phase)
        1: begin m_pc = m_tgt; m_phase = 0; end
        2: m_phase = 3;
        3: m_phase = 0;
        default: begin
          if (jmp) begin
            m_pc = tgt;
          end else if (br) begin
            nt = m_pc + {{8{off[7]}}, off};
            if (nt[15:8] != m_pc[15:8]) begin
              m_tgt = nt;
              m_pc = {m_pc[15:8], nt[7:0]};
              m_phase = 1;
            end else begin
              m_pc = nt;
            end
          end else if (push) begin
            m_phase = 2;
          end else if (inc) begin
            m_pc = m_pc + 16'd1;
          end
        end
      endcase
      ADDR_EN = adr;
      set_in(inc, jmp, br, push, tgt, off);
      #1;
      n_checks++;
      if ({PCH_DATA, PCL_DATA} !== m_pc) begin
        n_errors++;
        $display("FAIL b2b_data[%0d]: got %h, expected %h", i, {PCH_DATA, PCL_DATA}, m_pc);
      end
      expect_after("b2b", m_pc, m_phase != 0, m_phase == 2, m_phase == 3, adr && (m_phase < 2));
      tick();
    end
    ADDR_EN = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  initial begin
    RESET_N = 1'b0; ADDR_EN = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    test_reset();
    test_inc();
    test_branch_fwd();
    test_branch_back();
    test_push();
    test_priority();
    test_reset_abort();
    RESET_N = 1'b0;
    expect_after("b2b_reset", 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    RESET_N = 1'b1;
    test_back_to_back();
    tick();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
